// File: rtl/bus_stall_memory_pkg.sv
// Shared types for the Avalon-MM memory models: stall modes, transfer FSM states and the
// Galois LFSR step used to draw random wait-state counts.
package bus_mem_pkg;

   typedef enum logic [1:0] {
      STALL_NONE   = 2'd0,
      STALL_FIXED  = 2'd1,
      STALL_RANDOM = 2'd2
   } stall_mode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   // Right-shifting Galois form: feedback is the bit shifted out.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

endpackage

// File: rtl/bus_stall_memory_lfsr.sv
// Free-running 16-bit Galois LFSR; a zero seed would lock up, so it is replaced by 1.
module stall_lfsr
   import bus_mem_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] seed_i,
   output logic [15:0] state_o
);

   logic [15:0] state_q;
   logic [15:0] state_d;
   logic [15:0] seed_safe;

   assign seed_safe = (seed_i == 16'h0000) ? 16'h0001 : seed_i;
   assign state_d   = lfsr_next(state_q);
   assign state_o   = state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= seed_safe;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/bus_stall_memory.sv
// Avalon-MM slave memory with configurable wait states (none / fixed / LFSR-random),
// byte enables and sticky protocol / address-range error flags. One transfer at a time.
module bus_stall_memory
   import bus_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
   parameter int          STALL_MODE  = 2,
   parameter int          FIXED_STALL = 2,
   parameter int          STALL_BITS  = 3,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        waitrequest,
   output logic        err_protocol,
   output logic        err_range
);

   localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam stall_mode_t MODE  = stall_mode_t'(2'(STALL_MODE));

   mem_state_t  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [3:0]  be_q, be_d;
   logic        req_rd_q, req_rd_d;
   logic        req_wr_q, req_wr_d;
   logic        err_prot_q, err_prot_d;
   logic        err_range_q, err_range_d;

   logic [15:0]      lfsr_state;
   logic             lfsr_unused;
   logic [7:0]       stall_load;
   logic [29:0]      word_off;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic             op_wr;
   logic             req_dropped;
   logic             req_changed;
   logic             mem_we;
   logic [31:0]      mem_q [DEPTH_WORDS];

   stall_lfsr u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .seed_i  (LFSR_SEED),
      .state_o (lfsr_state)
   );

   assign lfsr_unused = ^lfsr_state;

   always_comb begin
      stall_load = 8'd0;
      case (MODE)
         STALL_NONE:  stall_load = 8'd0;
         STALL_FIXED: stall_load = 8'(FIXED_STALL);
         default:     stall_load = 8'(lfsr_state[STALL_BITS-1:0]);
      endcase
   end

   // Word offset in 30-bit wrap-around arithmetic; addresses below BASE_ADDR land far out of range.
   assign word_off = addr_q[31:2] - BASE_ADDR[31:2];
   assign in_range = ({2'b00, word_off} < 32'(DEPTH_WORDS));
   assign idx      = word_off[IDX_W-1:0];

   // read&write together is served as a read.
   assign op_wr       = req_wr_q & ~req_rd_q;
   assign req_dropped = ~read & ~write;
   assign req_changed = (read != req_rd_q) || (write != req_wr_q) || (address != addr_q) ||
                        (op_wr && ((byteenable != be_q) || (writedata != wdata_q)));

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      be_d        = be_q;
      req_rd_d    = req_rd_q;
      req_wr_d    = req_wr_q;
      err_prot_d  = err_prot_q;
      err_range_d = err_range_q;
      mem_we      = 1'b0;
      case (state_q)
         IDLE: begin
            if (read || write) begin
               addr_d   = address;
               req_rd_d = read;
               req_wr_d = write;
               be_d     = byteenable;
               wdata_d  = writedata;
               cnt_d    = stall_load;
               state_d  = WAIT;
               if (read && write) begin
                  err_prot_d = 1'b1;
               end
            end
         end
         WAIT: begin
            if (req_dropped) begin
               state_d    = IDLE;
               err_prot_d = 1'b1;
            end else begin
               if (req_changed) begin
                  err_prot_d = 1'b1;
               end
               if (cnt_q == 8'd0) begin
                  state_d = DONE;
                  if (!op_wr) begin
                     rdata_d = in_range ? mem_q[idx] : 32'h0000_0000;
                  end
                  if (!in_range) begin
                     err_range_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q - 8'd1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            if (req_dropped) begin
               err_prot_d = 1'b1;
            end else begin
               if (req_changed) begin
                  err_prot_d = 1'b1;
               end
               mem_we = op_wr && in_range;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         addr_q      <= 32'h0000_0000;
         wdata_q     <= 32'h0000_0000;
         rdata_q     <= 32'h0000_0000;
         be_q        <= 4'h0;
         req_rd_q    <= 1'b0;
         req_wr_q    <= 1'b0;
         err_prot_q  <= 1'b0;
         err_range_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         be_q        <= be_d;
         req_rd_q    <= req_rd_d;
         req_wr_q    <= req_wr_d;
         err_prot_q  <= err_prot_d;
         err_range_q <= err_range_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign readdata     = rdata_q;
   assign waitrequest  = (state_q != DONE);
   assign err_protocol = err_prot_q;
   assign err_range    = err_range_q;

endmodule

// File: tb/tb_bus_stall_memory.sv
// Drives three memory instances (no stall, fixed stall 3, LFSR-random stall) as an Avalon master
// and checks latency, read data, byte lanes, range/protocol flags and reset behaviour.
module tb_bus_stall_memory;

   localparam logic [31:0] BASE  = 32'hBFC00000;
   localparam int          DEPTH = 16;

   typedef struct {
      int          k;
      bit          rd;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      bit          erng;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        rd_s [3];
   logic        wr_s [3];
   logic [31:0] ad_s [3];
   logic [3:0]  be_s [3];
   logic [31:0] wd_s [3];
   logic [31:0] rdat_s [3];
   logic        wreq_s [3];
   logic        eprot_s [3];
   logic        erng_s [3];

   logic [31:0] rdat0, rdat1, rdat2;
   logic        wreq0, wreq1, wreq2, eprot0, eprot1, eprot2, erng0, erng1, erng2;

   always_comb begin
      rdat_s[0] = rdat0;  rdat_s[1] = rdat1;  rdat_s[2] = rdat2;
      wreq_s[0] = wreq0;  wreq_s[1] = wreq1;  wreq_s[2] = wreq2;
      eprot_s[0] = eprot0; eprot_s[1] = eprot1; eprot_s[2] = eprot2;
      erng_s[0] = erng0;  erng_s[1] = erng1;  erng_s[2] = erng2;
   end

   bus_stall_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .STALL_MODE(0)) u_dut0 (
      .clk(clk), .reset(rst_n), .address(ad_s[0]), .read(rd_s[0]), .write(wr_s[0]),
      .byteenable(be_s[0]), .writedata(wd_s[0]), .readdata(rdat0), .waitrequest(wreq0),
      .err_protocol(eprot0), .err_range(erng0));

   bus_stall_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .STALL_MODE(1), .FIXED_STALL(3)) u_dut1 (
      .clk(clk), .reset(rst_n), .address(ad_s[1]), .read(rd_s[1]), .write(wr_s[1]),
      .byteenable(be_s[1]), .writedata(wd_s[1]), .readdata(rdat1), .waitrequest(wreq1),
      .err_protocol(eprot1), .err_range(erng1));

   bus_stall_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .STALL_MODE(2), .STALL_BITS(3),
                      .LFSR_SEED(16'hACE1)) u_dut2 (
      .clk(clk), .reset(rst_n), .address(ad_s[2]), .read(rd_s[2]), .write(wr_s[2]),
      .byteenable(be_s[2]), .writedata(wd_s[2]), .readdata(rdat2), .waitrequest(wreq2),
      .err_protocol(eprot2), .err_range(erng2));

   // Reference LFSR: Galois, mask 16'hB400, stepping every cycle out of reset.
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
   end

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] mdl [DEPTH];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input int k, input bit r, input bit w, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd, output logic [31:0] rdv);
      int lat;
      int exp_lat;
      case (k)
         0:       exp_lat = 2;
         1:       exp_lat = 5;
         default: exp_lat = 2 + int'(m_lfsr[2:0]);
      endcase
      rd_s[k] = r; wr_s[k] = w; ad_s[k] = a; be_s[k] = be; wd_s[k] = wd;
      lat = 0;
      while (wreq_s[k] === 1'b1 && lat < 300) begin
         tick();
         lat++;
      end
      rdv = rdat_s[k];
      chk($sformatf("latency dut%0d addr=%h", k, a), lat, exp_lat);
      $display("xfer dut%0d rd=%0b wr=%0b addr=%h be=%b wd=%h -> lat=%0d readdata=%h",
               k, r, w, a, be, wd, lat, rdv);
      tick();
      rd_s[k] = 1'b0; wr_s[k] = 1'b0;
   endtask

   vec_t        tv [19];
   logic [31:0] rv;
   logic [31:0] last_rd;
   bit          rw;
   int          wi;
   logic [3:0]  rbe;
   logic [31:0] rwd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{0, 1'b0, BASE,               4'hF, 32'h24020005, 32'h00000000, 1'b0};
      tv[1]  = '{0, 1'b1, BASE,               4'hF, 32'h0,        32'h24020005, 1'b0};
      tv[2]  = '{0, 1'b0, BASE + 32'h4,       4'hC, 32'hAABBCCDD, 32'h24020005, 1'b0};
      tv[3]  = '{0, 1'b1, BASE + 32'h4,       4'hF, 32'h0,        32'hAABB0000, 1'b0};
      tv[4]  = '{0, 1'b0, BASE + 32'h4,       4'h0, 32'hFFFFFFFF, 32'hAABB0000, 1'b0};
      tv[5]  = '{0, 1'b1, BASE + 32'h4,       4'hF, 32'h0,        32'hAABB0000, 1'b0};
      tv[6]  = '{0, 1'b0, BASE + 32'h3C,      4'hF, 32'h12345678, 32'hAABB0000, 1'b0};
      tv[7]  = '{0, 1'b1, BASE + 32'h3C,      4'hF, 32'h0,        32'h12345678, 1'b0};
      tv[8]  = '{0, 1'b1, BASE - 32'h4,       4'hF, 32'h0,        32'h00000000, 1'b1};
      tv[9]  = '{0, 1'b1, BASE + 32'h40,      4'hF, 32'h0,        32'h00000000, 1'b1};
      tv[10] = '{0, 1'b0, BASE + 32'h40,      4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      tv[11] = '{0, 1'b0, BASE - 32'h4,       4'hF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      tv[12] = '{0, 1'b1, BASE,               4'hF, 32'h0,        32'h24020005, 1'b1};
      tv[13] = '{0, 1'b1, BASE + 32'h3C,      4'hF, 32'h0,        32'h12345678, 1'b1};
      tv[14] = '{1, 1'b0, BASE,               4'h3, 32'hDEADBEEF, 32'h00000000, 1'b0};
      tv[15] = '{1, 1'b1, BASE,               4'hF, 32'h0,        32'h0000BEEF, 1'b0};
      tv[16] = '{1, 1'b0, BASE + 32'h8,       4'h4, 32'h11223344, 32'h0000BEEF, 1'b0};
      tv[17] = '{1, 1'b1, BASE + 32'h8,       4'hF, 32'h0,        32'h00220000, 1'b0};
      tv[18] = '{1, 1'b1, BASE,               4'hF, 32'h0,        32'h0000BEEF, 1'b0};

      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rd_s[k] = 1'b0; wr_s[k] = 1'b0; ad_s[k] = '0; be_s[k] = '0; wd_s[k] = '0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset waitrequest dut%0d", k), 32'(wreq_s[k]), 32'd1);
         chk($sformatf("reset readdata dut%0d", k), rdat_s[k], 32'h0);
         chk($sformatf("reset err_protocol dut%0d", k), 32'(eprot_s[k]), 32'd0);
         chk($sformatf("reset err_range dut%0d", k), 32'(erng_s[k]), 32'd0);
      end
      rst_n = 1'b1;
      tick();

      // Zero-fill every instance through the bus so the reference contents are known.
      for (int k = 0; k < 3; k++) begin
         for (int w = 0; w < DEPTH; w++) begin
            xfer(k, 1'b0, 1'b1, BASE + 32'(4 * w), 4'hF, 32'h0, rv);
         end
      end
      for (int w = 0; w < DEPTH; w++) mdl[w] = 32'h0;

      for (int i = 0; i < 19; i++) begin
         xfer(tv[i].k, tv[i].rd, !tv[i].rd, tv[i].a, tv[i].be, tv[i].wd, rv);
         chk($sformatf("vec%0d readdata", i), rv, tv[i].exp_rd);
         chk($sformatf("vec%0d err_range", i), 32'(erng_s[tv[i].k]), 32'(tv[i].erng));
         chk($sformatf("vec%0d err_protocol", i), 32'(eprot_s[tv[i].k]), 32'd0);
      end

      // Random stalls against the LFSR and memory reference.
      last_rd = 32'h0;
      for (int i = 0; i < 100; i++) begin
         rw  = 1'($urandom_range(0, 1));
         wi  = int'($urandom_range(0, DEPTH - 1));
         rbe = 4'($urandom);
         rwd = $urandom;
         xfer(2, !rw, rw, BASE + 32'(4 * wi), rbe, rwd, rv);
         if (rw) begin
            chk($sformatf("rand%0d readdata held", i), rv, last_rd);
            for (int b = 0; b < 4; b++) if (rbe[b]) mdl[wi][8*b +: 8] = rwd[8*b +: 8];
         end else begin
            chk($sformatf("rand%0d readdata", i), rv, mdl[wi]);
            last_rd = mdl[wi];
         end
      end
      chk("rand err_protocol", 32'(eprot_s[2]), 32'd0);
      chk("rand err_range", 32'(erng_s[2]), 32'd0);

      // Address changed mid-transfer: latched address still used, flag raised.
      rd_s[0] = 1'b1; wr_s[0] = 1'b0; ad_s[0] = BASE + 32'h4; be_s[0] = 4'hF; wd_s[0] = 32'h0;
      tick();
      ad_s[0] = BASE + 32'h3C;
      tick();
      chk("addr change waitrequest", 32'(wreq_s[0]), 32'd0);
      chk("addr change readdata", rdat_s[0], 32'hAABB0000);
      $display("xfer dut0 read addr=%h changed to %h mid-transfer -> readdata=%h", BASE + 32'h4,
               BASE + 32'h3C, rdat_s[0]);
      tick();
      rd_s[0] = 1'b0;
      chk("addr change err_protocol", 32'(eprot_s[0]), 32'd1);

      // Write dropped while waiting: abort, nothing committed.
      rd_s[1] = 1'b0; wr_s[1] = 1'b1; ad_s[1] = BASE + 32'hC; be_s[1] = 4'hF; wd_s[1] = 32'h55555555;
      tick();
      tick();
      wr_s[1] = 1'b0;
      tick();
      $display("xfer dut1 write addr=%h dropped in WAIT", BASE + 32'hC);
      chk("abort waitrequest", 32'(wreq_s[1]), 32'd1);
      chk("abort err_protocol", 32'(eprot_s[1]), 32'd1);
      tick();
      chk("abort stays idle", 32'(wreq_s[1]), 32'd1);
      xfer(1, 1'b1, 1'b0, BASE + 32'hC, 4'hF, 32'h0, rv);
      chk("abort word unchanged", rv, 32'h0);
      chk("abort err_protocol sticky", 32'(eprot_s[1]), 32'd1);
      xfer(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, rv);
      chk("pre-reset readdata", rv, 32'h0000BEEF);

      // Reset during the wait of a write.
      rd_s[1] = 1'b0; wr_s[1] = 1'b1; ad_s[1] = BASE; be_s[1] = 4'hF; wd_s[1] = 32'h99999999;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      $display("xfer dut1 write addr=%h interrupted by reset", BASE);
      chk("midreset waitrequest", 32'(wreq_s[1]), 32'd1);
      chk("midreset readdata", rdat_s[1], 32'h0);
      chk("midreset err_protocol dut1", 32'(eprot_s[1]), 32'd0);
      chk("midreset err_protocol dut0", 32'(eprot_s[0]), 32'd0);
      chk("midreset err_range dut0", 32'(erng_s[0]), 32'd0);
      wr_s[1] = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      xfer(1, 1'b1, 1'b0, BASE, 4'hF, 32'h0, rv);
      chk("post-reset word unchanged", rv, 32'h0000BEEF);

      // read and write together: served as a read, flag raised, no write.
      xfer(0, 1'b1, 1'b1, BASE, 4'hF, 32'h0, rv);
      chk("rd&wr readdata", rv, 32'h24020005);
      chk("rd&wr err_protocol", 32'(eprot_s[0]), 32'd1);
      xfer(0, 1'b1, 1'b0, BASE, 4'hF, 32'h0, rv);
      chk("rd&wr no write", rv, 32'h24020005);
      chk("rd&wr err_range", 32'(erng_s[0]), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
